inv_sched: RTL and testbench
============================

INV_SCHED -- requirements
Module: inv_sched

Interface
REQ-001 Parameter: IP_WIDTH, default 7, operand/result bit width passed unchanged to the internal INV_IP instance.
REQ-002 Parameter: FIFO_DEPTH, fixed at 2, entries per requester queue.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 req0_valid  input  1  requester 0 offers an operand pair.
REQ-006 req0_ready  output  1  requester 0 queue can accept this cycle.
REQ-007 req0_a / req0_p  input  IP_WIDTH each  requester 0 value to invert / prime modulus.
REQ-008 req1_valid, req1_ready, req1_a, req1_p  same directions, widths and meanings for requester 1.
REQ-009 out_valid  output  1  result register holds a valid result.
REQ-010 out_ready  input  1  consumer accepts the result this cycle.
REQ-011 out_id  output  1  requester index of the held result.
REQ-012 out_inv  output  IP_WIDTH  modular inverse of a mod p.
REQ-013 out_err  output  1  operand pair was illegal; out_inv forced to 0.
REQ-014 busy  output  1  high when any queue is non-empty or out_valid=1.

Function
REQ-015 One INV_IP instance, shared by both requesters: IN_1 = granted a, IN_2 = granted p, OUT_INV combinational.
REQ-016 Accept on req_k_valid && req_k_ready at a clock edge; pair pushed into FIFO k.
REQ-017 req_k_ready = FIFO k count < 2, from registered count only; no push into a full FIFO, even when it pops in the same cycle.
REQ-018 Issue slot open when out_valid=0 or out_ready=1.
REQ-019 Arbitration when the issue slot is open: exactly one non-empty FIFO -> grant it; both non-empty -> grant the FIFO != last_grant.
REQ-020 On grant: pop the FIFO head, load out_inv/out_id/out_err from the head, set out_valid=1, set last_grant=granted index.
REQ-021 Slot open and both FIFOs empty -> out_valid clears when out_ready=1; otherwise out_valid holds.
REQ-022 Output holds stable (valid, id, inv, err) while out_valid=1 and out_ready=0.
REQ-023 Latency: pair accepted at edge E reaches the output at edge E+1 at the earliest (empty queues, open slot); no bypass in the same cycle.
REQ-024 Illegal pair (a==0, p<2, or a>=p): out_err=1, out_inv=0; the IP output is ignored.
REQ-025 Legal pair: out_err=0, out_inv = IP result, with (a*out_inv) mod p == 1.
REQ-026 Per-requester ordering preserved (FIFO); no result dropped or duplicated.
REQ-027 Simultaneous push and pop on the same FIFO in one cycle: count unchanged, data order correct.
REQ-028 Starvation-free: with both queues persistently non-empty, grants alternate 0,1,0,1,...

Reset
REQ-029 While rst=1: FIFOs emptied, out_valid=0, out_id=0, out_inv=0, out_err=0, busy=0, req0_ready=req1_ready=1, last_grant=1 (port 0 wins the first contention).
REQ-030 Reset mid-operation: queued and held results are discarded; no output after release until new accepts.

Verification
REQ-031 Single request: req0 a=3 p=7 accepted at edge E -> out_valid=1 after E+1, out_id=0, out_inv=5, out_err=0.
REQ-032 Contention: same edge req0 (a=3,p=7) and req1 (a=2,p=11), out_ready=1 -> results id0 inv=5, then id1 inv=6 on consecutive cycles.
REQ-033 Backpressure: out_ready=0; req0 sends 4 pairs -> first occupies the output, next 2 fill the FIFO, req0_ready=0 at the 4th; raise out_ready -> all 3 drain in order, req0_ready returns to 1.
REQ-034 Illegal operands: req1 a=0 p=7 -> out_err=1, out_inv=0, out_id=1; a=9 p=7 -> out_err=1.
REQ-035 Fairness: both queues kept full for 8 results -> out_id sequence 0,1,0,1,0,1,0,1.
REQ-036 Reset mid-run: assert rst with 2 entries queued and out_valid=1 -> all outputs 0 immediately, busy=0, both ready=1.

Source files
------------

// File: rtl/inv_sched.sv
// inv_sched: two-requester scheduler in front of one shared modular-inverse IP.
// Each requester owns a 2-entry operand FIFO. A round-robin arbiter feeds the
// granted FIFO head through the inverse IP into a single result register.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   req{0,1}_valid/_ready       operand handshake per requester
//   req{0,1}_a / req{0,1}_p     value to invert / prime modulus
//   out_valid / out_ready       result handshake
//   out_id                      requester index of the held result
//   out_inv                     modular inverse (0 when out_err)
//   out_err                     operand pair was illegal
//   busy                        any queue non-empty or a result is held

// Combinational modular inverse: smallest x in [1, p-1] with (a*x) mod p == 1,
// or 0 when no such x exists.
module inv_ip #(
    parameter int IP_WIDTH = 7
) (
    input  logic [IP_WIDTH-1:0] IN_1,
    input  logic [IP_WIDTH-1:0] IN_2,
    output logic [IP_WIDTH-1:0] OUT_INV
);
    logic                    found_s;
    logic [IP_WIDTH-1:0]     cand_s;
    logic [2*IP_WIDTH-1:0]   prod_s;
    logic [2*IP_WIDTH-1:0]   div_s;

    // Exhaustive candidate search; the divisor is clamped so p<2 never divides by zero.
    always_comb begin
        OUT_INV = {IP_WIDTH{1'b0}};
        found_s = 1'b0;
        cand_s  = {IP_WIDTH{1'b0}};
        prod_s  = {(2*IP_WIDTH){1'b0}};
        if (IN_2 < IP_WIDTH'(2)) begin
            div_s = (2*IP_WIDTH)'(2);
        end else begin
            div_s = {{IP_WIDTH{1'b0}}, IN_2};
        end
        for (int i = 1; i < (1 << IP_WIDTH); i++) begin
            cand_s = IP_WIDTH'(i);
            prod_s = {{IP_WIDTH{1'b0}}, IN_1} * {{IP_WIDTH{1'b0}}, cand_s};
            if (!found_s && (cand_s < IN_2) && ((prod_s % div_s) == (2*IP_WIDTH)'(1))) begin
                OUT_INV = cand_s;
                found_s = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end
endmodule

module inv_sched #(
    parameter int IP_WIDTH   = 7,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    output logic                req0_ready,
    input  logic [IP_WIDTH-1:0] req0_a,
    input  logic [IP_WIDTH-1:0] req0_p,
    input  logic                req1_valid,
    output logic                req1_ready,
    input  logic [IP_WIDTH-1:0] req1_a,
    input  logic [IP_WIDTH-1:0] req1_p,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_id,
    output logic [IP_WIDTH-1:0] out_inv,
    output logic                out_err,
    output logic                busy
);
    // FIFO storage and pointers, indexed [requester][entry]
    logic [IP_WIDTH-1:0] a_mem_q [2][FIFO_DEPTH];
    logic [IP_WIDTH-1:0] a_mem_d [2][FIFO_DEPTH];
    logic [IP_WIDTH-1:0] p_mem_q [2][FIFO_DEPTH];
    logic [IP_WIDTH-1:0] p_mem_d [2][FIFO_DEPTH];
    logic                rd_ptr_q [2];
    logic                rd_ptr_d [2];
    logic                wr_ptr_q [2];
    logic                wr_ptr_d [2];
    logic [1:0]          cnt_q [2];
    logic [1:0]          cnt_d [2];

    logic                last_grant_q, last_grant_d;
    logic                out_valid_q, out_valid_d;
    logic                out_id_q, out_id_d;
    logic [IP_WIDTH-1:0] out_inv_q, out_inv_d;
    logic                out_err_q, out_err_d;

    logic [IP_WIDTH-1:0] in_a_s [2];
    logic [IP_WIDTH-1:0] in_p_s [2];
    logic [1:0]          push_s, pop_s, ready_s, nonempty_s;
    logic                slot_open_s, gnt_valid_s, gnt_idx_s, illegal_s;
    logic [IP_WIDTH-1:0] head_a_s, head_p_s, ip_inv_s;

    // Requester inputs gathered into arrays; ready depends only on registered counts.
    always_comb begin
        in_a_s[0]     = req0_a;
        in_p_s[0]     = req0_p;
        in_a_s[1]     = req1_a;
        in_p_s[1]     = req1_p;
        ready_s[0]    = (cnt_q[0] < 2'd2);
        ready_s[1]    = (cnt_q[1] < 2'd2);
        nonempty_s[0] = (cnt_q[0] != 2'd0);
        nonempty_s[1] = (cnt_q[1] != 2'd0);
        push_s[0]     = req0_valid && ready_s[0];
        push_s[1]     = req1_valid && ready_s[1];
    end

    // Round-robin arbitration: on contention the requester not granted last time wins.
    always_comb begin
        slot_open_s = !out_valid_q || out_ready;
        gnt_valid_s = 1'b0;
        gnt_idx_s   = 1'b0;
        if (slot_open_s) begin
            if (nonempty_s[0] && nonempty_s[1]) begin
                gnt_valid_s = 1'b1;
                gnt_idx_s   = ~last_grant_q;
            end else if (nonempty_s[0]) begin
                gnt_valid_s = 1'b1;
                gnt_idx_s   = 1'b0;
            end else if (nonempty_s[1]) begin
                gnt_valid_s = 1'b1;
                gnt_idx_s   = 1'b1;
            end else begin
                gnt_valid_s = 1'b0;
            end
        end else begin
            gnt_valid_s = 1'b0;
        end
        pop_s[0]  = gnt_valid_s && (gnt_idx_s == 1'b0);
        pop_s[1]  = gnt_valid_s && (gnt_idx_s == 1'b1);
        head_a_s  = a_mem_q[gnt_idx_s][rd_ptr_q[gnt_idx_s]];
        head_p_s  = p_mem_q[gnt_idx_s][rd_ptr_q[gnt_idx_s]];
        illegal_s = (head_a_s == {IP_WIDTH{1'b0}}) || (head_p_s < IP_WIDTH'(2)) ||
                    (head_a_s >= head_p_s);
    end

    inv_ip #(.IP_WIDTH(IP_WIDTH)) u_inv_ip (
        .IN_1    (head_a_s),
        .IN_2    (head_p_s),
        .OUT_INV (ip_inv_s)
    );

    // FIFO next state: write at wr_ptr on push, advance rd_ptr on pop.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            a_mem_d[k]  = a_mem_q[k];
            p_mem_d[k]  = p_mem_q[k];
            rd_ptr_d[k] = rd_ptr_q[k];
            wr_ptr_d[k] = wr_ptr_q[k];
            cnt_d[k]    = cnt_q[k];
            if (push_s[k]) begin
                a_mem_d[k][wr_ptr_q[k]] = in_a_s[k];
                p_mem_d[k][wr_ptr_q[k]] = in_p_s[k];
                wr_ptr_d[k]             = ~wr_ptr_q[k];
            end else begin
                wr_ptr_d[k] = wr_ptr_q[k];
            end
            if (pop_s[k]) begin
                rd_ptr_d[k] = ~rd_ptr_q[k];
            end else begin
                rd_ptr_d[k] = rd_ptr_q[k];
            end
            case ({push_s[k], pop_s[k]})
                2'b10:   cnt_d[k] = cnt_q[k] + 2'd1;
                2'b01:   cnt_d[k] = cnt_q[k] - 2'd1;
                default: cnt_d[k] = cnt_q[k];
            endcase
        end
    end

    // Result register: load on grant, clear when drained with nothing to issue.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_id_d     = out_id_q;
        out_inv_d    = out_inv_q;
        out_err_d    = out_err_q;
        last_grant_d = last_grant_q;
        if (gnt_valid_s) begin
            out_valid_d  = 1'b1;
            out_id_d     = gnt_idx_s;
            out_err_d    = illegal_s;
            out_inv_d    = illegal_s ? {IP_WIDTH{1'b0}} : ip_inv_s;
            last_grant_d = gnt_idx_s;
        end else if (slot_open_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // State registers; last_grant resets to 1 so requester 0 wins first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                for (int e = 0; e < FIFO_DEPTH; e++) begin
                    a_mem_q[k][e] <= {IP_WIDTH{1'b0}};
                    p_mem_q[k][e] <= {IP_WIDTH{1'b0}};
                end
                rd_ptr_q[k] <= 1'b0;
                wr_ptr_q[k] <= 1'b0;
                cnt_q[k]    <= 2'd0;
            end
            last_grant_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_id_q     <= 1'b0;
            out_inv_q    <= {IP_WIDTH{1'b0}};
            out_err_q    <= 1'b0;
        end else begin
            a_mem_q      <= a_mem_d;
            p_mem_q      <= p_mem_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_id_q     <= out_id_d;
            out_inv_q    <= out_inv_d;
            out_err_q    <= out_err_d;
        end
    end

    assign req0_ready = ready_s[0];
    assign req1_ready = ready_s[1];
    assign out_valid  = out_valid_q;
    assign out_id     = out_id_q;
    assign out_inv    = out_inv_q;
    assign out_err    = out_err_q;
    assign busy       = nonempty_s[0] || nonempty_s[1] || out_valid_q;
endmodule

// File: tb/tb_inv_sched.sv
// Directed testbench for inv_sched with hand-computed expected inverses.
module tb_inv_sched;
    localparam int W = 7;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid, out_ready;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a, req0_p, req1_a, req1_p;
    logic         out_valid, out_id, out_err, busy;
    logic [W-1:0] out_inv;

    int n_checks = 0;
    int n_fail   = 0;

    inv_sched #(.IP_WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_p     (req0_p),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_p     (req1_p),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_id     (out_id),
        .out_inv    (out_inv),
        .out_err    (out_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        req0_valid = 1'b0; req1_valid = 1'b0; out_ready = 1'b0;
        req0_a = '0; req0_p = '0; req1_a = '0; req1_p = '0;
    endtask

    // Leaves the caller just after a falling edge with reset released.
    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One isolated transaction on requester k, checked for id, inverse and error.
    task automatic single(input int k, input int a, input int p, input int exp_inv,
                          input int exp_err, input string tag);
        int waited;
        out_ready = 1'b1;
        if (k == 0) begin
            req0_valid = 1'b1; req0_a = W'(a); req0_p = W'(p);
        end else begin
            req1_valid = 1'b1; req1_a = W'(a); req1_p = W'(p);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waited = 0;
        while (!out_valid && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        check_val({tag, "_valid"}, 32'(out_valid), 32'd1);
        check_val({tag, "_id"},    32'(out_id),    32'(k));
        check_val({tag, "_inv"},   32'(out_inv),   32'(exp_inv));
        check_val({tag, "_err"},   32'(out_err),   32'(exp_err));
        @(negedge clk);
        check_val({tag, "_drain"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int got;
        int cyc;
        int bp_a [4];
        bp_a = '{3, 4, 5, 6};

        // Reset state, sampled while rst is held
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        check_val("rst_valid", 32'(out_valid), 32'd0);
        check_val("rst_inv",   32'(out_inv),   32'd0);
        check_val("rst_id",    32'(out_id),    32'd0);
        check_val("rst_err",   32'(out_err),   32'd0);
        check_val("rst_busy",  32'(busy),      32'd0);
        check_val("rst_rdy0",  32'(req0_ready), 32'd1);
        check_val("rst_rdy1",  32'(req1_ready), 32'd1);
        rst = 1'b0;
        @(negedge clk);

        // Single request with exact latency: no output in the cycle after accept
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 7'd3; req0_p = 7'd7;
        @(negedge clk);
        req0_valid = 1'b0;
        check_val("lat_nobypass", 32'(out_valid), 32'd0);
        check_val("lat_busy",     32'(busy),      32'd1);
        @(negedge clk);
        check_val("lat_valid", 32'(out_valid), 32'd1);
        check_val("lat_id",    32'(out_id),    32'd0);
        check_val("lat_inv",   32'(out_inv),   32'd5);
        check_val("lat_err",   32'(out_err),   32'd0);
        @(negedge clk);
        check_val("lat_clear", 32'(out_valid), 32'd0);

        // Contention from reset: requester 0 first, then 1 on the next cycle
        do_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 7'd3; req0_p = 7'd7;
        req1_valid = 1'b1; req1_a = 7'd2; req1_p = 7'd11;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        check_val("cont0_id",  32'(out_id),  32'd0);
        check_val("cont0_inv", 32'(out_inv), 32'd5);
        @(negedge clk);
        check_val("cont1_valid", 32'(out_valid), 32'd1);
        check_val("cont1_id",    32'(out_id),    32'd1);
        check_val("cont1_inv",   32'(out_inv),   32'd6);
        @(negedge clk);
        check_val("cont_clear", 32'(out_valid), 32'd0);

        // Backpressure: output + 2 queued, 4th offer refused, then in-order drain
        do_reset();
        out_ready = 1'b0;
        req0_p = 7'd7;
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("bp_rdy%0d", i), 32'(req0_ready), (i < 3) ? 32'd1 : 32'd0);
            req0_valid = 1'b1;
            req0_a = W'(bp_a[i]);
            @(negedge clk);
        end
        req0_valid = 1'b0;
        check_val("bp_hold_valid", 32'(out_valid), 32'd1);
        check_val("bp_hold_inv",   32'(out_inv),   32'd5);
        check_val("bp_full",       32'(req0_ready), 32'd0);
        @(negedge clk);
        check_val("bp_stable_inv", 32'(out_inv), 32'd5);
        out_ready = 1'b1;
        @(negedge clk);
        check_val("bp_d1_inv", 32'(out_inv),    32'd2);
        check_val("bp_d1_rdy", 32'(req0_ready), 32'd1);
        @(negedge clk);
        check_val("bp_d2_valid", 32'(out_valid), 32'd1);
        check_val("bp_d2_inv",   32'(out_inv),   32'd3);
        @(negedge clk);
        check_val("bp_end_valid", 32'(out_valid), 32'd0);
        check_val("bp_end_busy",  32'(busy),      32'd0);

        // Illegal and boundary operand pairs, plus further legal patterns
        single(1, 0,   7,   0,   1, "ill_a0");
        single(1, 9,   7,   0,   1, "ill_agep");
        single(0, 7,   7,   0,   1, "ill_aeqp");
        single(0, 1,   1,   0,   1, "ill_p1");
        single(0, 5,   11,  9,   0, "leg_5_11");
        single(1, 12,  13,  12,  0, "leg_12_13");
        single(1, 1,   13,  1,   0, "leg_1_13");
        single(0, 126, 127, 126, 0, "leg_126_127");

        // Fairness: both queues persistently full, ids must alternate from 0
        do_reset();
        out_ready = 1'b1;
        req0_valid = 1'b1; req0_a = 7'd3; req0_p = 7'd7;
        req1_valid = 1'b1; req1_a = 7'd2; req1_p = 7'd11;
        got = 0;
        cyc = 0;
        while (got < 8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (out_valid) begin
                check_val($sformatf("fair_id%0d", got), 32'(out_id), 32'(got % 2));
                check_val($sformatf("fair_inv%0d", got), 32'(out_inv),
                          (got % 2 == 1) ? 32'd6 : 32'd5);
                got++;
            end
        end
        check_val("fair_count", 32'(got), 32'd8);
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Reset mid-run with a held result and two queued entries
        do_reset();
        out_ready = 1'b0;
        req1_valid = 1'b1; req1_a = 7'd2; req1_p = 7'd11;
        repeat (3) @(negedge clk);
        req1_valid = 1'b0;
        check_val("mid_pre_valid", 32'(out_valid),  32'd1);
        check_val("mid_pre_id",    32'(out_id),     32'd1);
        check_val("mid_pre_rdy1",  32'(req1_ready), 32'd0);
        rst = 1'b1;
        #1;
        check_val("mid_valid", 32'(out_valid),  32'd0);
        check_val("mid_id",    32'(out_id),     32'd0);
        check_val("mid_inv",   32'(out_inv),    32'd0);
        check_val("mid_err",   32'(out_err),    32'd0);
        check_val("mid_busy",  32'(busy),       32'd0);
        check_val("mid_rdy0",  32'(req0_ready), 32'd1);
        check_val("mid_rdy1",  32'(req1_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_val($sformatf("mid_post_valid%0d", i), 32'(out_valid), 32'd0);
            check_val($sformatf("mid_post_busy%0d", i),  32'(busy),      32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
